// File: rtl/custom_instr_pkg.sv
// Shared types for the custom-instruction result path: the queued result
// entry and the decode of the FIFO head against the commit scoreboard.
package custom_instr_pkg;

    localparam int CI_ID_WIDTH = 4;

    typedef struct packed {
        logic [CI_ID_WIDTH-1:0] id;
        logic [4:0]             rd;
        logic                   we;
        logic [31:0]            data;
    } result_entry_t;

    typedef enum logic [1:0] {
        HEAD_EMPTY,
        HEAD_WAIT,
        HEAD_SEND,
        HEAD_DROP
    } head_state_e;

endpackage

// File: rtl/if_xif.sv
// Coprocessor result channel: the coprocessor offers one result per
// handshake, and the core accepts it with result_ready.
interface if_xif;
    import custom_instr_pkg::*;

    logic          result_valid;
    logic          result_ready;
    result_entry_t result;

    modport coproc_result (
        output result_valid,
        output result,
        input  result_ready
    );

endinterface

// File: rtl/custom_result_fifo.sv
// Result FIFO. Pointers carry one extra wrap bit, so equal pointers mean
// empty. The occupancy count is kept separately so that "full" is a register compare.
module custom_result_fifo
    import custom_instr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  result_entry_t entry_i,
    input  logic          pop_i,
    output result_entry_t head_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

    result_entry_t mem [DEPTH];
    logic [AW:0]   wptr, rptr, count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_i) wptr <= wptr + 1'b1;
            if (pop_i)  rptr <= rptr + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left without reset; empty_o masks stale contents.
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wptr[AW-1:0]] <= entry_i;
    end

    assign head_o  = mem[rptr[AW-1:0]];
    assign empty_o = (wptr == rptr);
    assign full_o  = (count == CNT_FULL);

endmodule

// File: rtl/custom_result_stage.sv
// Holds completed custom-instruction results until their commit/kill
// decision arrives, then either forwards them on the result channel or drops them.
module custom_result_stage
    import custom_instr_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = CI_ID_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ex_valid_i,
    output logic                ex_ready_o,
    input  logic [ID_WIDTH-1:0] ex_id_i,
    input  logic [4:0]          ex_rd_addr_i,
    input  logic                ex_we_i,
    input  logic [31:0]         ex_data_i,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    if_xif.coproc_result        xif_result
);

    localparam int NUM_IDS = 1 << ID_WIDTH;

    result_entry_t       push_entry, head;
    logic                push, pop, fifo_full, fifo_empty;
    logic [NUM_IDS-1:0]  sb_committed, sb_killed;
    logic [ID_WIDTH-1:0] head_id;
    head_state_e         head_state;

    assign push_entry = '{id: ex_id_i, rd: ex_rd_addr_i, we: ex_we_i, data: ex_data_i};
    assign ex_ready_o = !fifo_full;
    assign push       = ex_valid_i && ex_ready_o;
    assign head_id    = head.id;

    custom_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        head_state = HEAD_EMPTY;
        if (!fifo_empty) begin
            if (!sb_committed[head_id])  head_state = HEAD_WAIT;
            else if (sb_killed[head_id]) head_state = HEAD_DROP;
            else                         head_state = HEAD_SEND;
        end
    end

    assign pop = (head_state == HEAD_DROP) ||
                 ((head_state == HEAD_SEND) && xif_result.result_ready);

    // A commit landing in the same cycle that the head is retired for the same id
    // wins, because its write comes later in this block.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_committed <= '0;
            sb_killed    <= '0;
        end else begin
            if (pop) begin
                sb_committed[head_id] <= 1'b0;
                sb_killed[head_id]    <= 1'b0;
            end
            if (commit_valid_i) begin
                sb_committed[commit_id_i] <= 1'b1;
                sb_killed[commit_id_i]    <= commit_kill_i;
            end
        end
    end

    assign xif_result.result_valid = (head_state == HEAD_SEND);
    assign xif_result.result       = fifo_empty ? '0 : head;

endmodule
